w_forward_splitter: RTL and testbench
=====================================

W_FORWARD_SPLITTER -- requirements
Module: w_forward_splitter

Interface
REQ-001 Parameter CHECK_LEN, default 1: when 1, burst-length checking drives LEN_ERR; when 0, LEN_ERR SHALL be tied 0.
REQ-002 CLK  input  1  clock; all state on rising edge.
REQ-003 RESETn  input  1  reset, asynchronous, active-low.
REQ-004 DATA  input  77  merged AW/W stream word.
REQ-005 VALID  input  1  DATA valid.
REQ-006 READY  output  1  stream word accepted when VALID && READY.
REQ-007 AWID 8, AWADDR 36, AWLEN 8, AWSIZE 3, AWBURST 2, AWLOCK 1, AWCACHE 4, AWPROT 3, AWQOS 4, AWREGION 4, AWUSER 4: outputs, AXI4 write-address fields.
REQ-008 AWVALID  output  1 / AWREADY  input  1  AXI4 AW handshake.
REQ-009 WDATA 64, WSTRB 8, WUSER 4, WLAST 1: outputs, AXI4 write-data fields.
REQ-010 WVALID  output  1 / WREADY  input  1  AXI4 W handshake.
REQ-011 LEN_ERR  output  1  sticky burst-length mismatch flag.
REQ-012 ERR_CLR  input  1  synchronous clear of LEN_ERR.

Function
REQ-013 Command word layout, MSB first: AWID[76:69], AWADDR[68:33], AWLEN[32:25], AWSIZE[24:22], AWBURST[21:20], AWLOCK[19], AWCACHE[18:15], AWPROT[14:12], AWQOS[11:8], AWREGION[7:4], AWUSER[3:0].
REQ-014 Data word layout: WDATA[76:13], WSTRB[12:5], WUSER[4:1], WLAST[0].
REQ-015 Two-state FSM: CMD (word is a command), DATA (word is a W beat); reset state CMD.
REQ-016 CMD -> DATA on stream handshake in CMD; DATA -> CMD on stream handshake with DATA[0]=1; otherwise hold.
REQ-017 Each output channel SHALL be a one-entry register slice (payload + valid); outputs driven only from registers.
REQ-018 READY = (state==CMD) ? (!AWVALID || AWREADY) : (!WVALID || WREADY); no dependency on VALID.
REQ-019 Accepted command word SHALL appear on AW outputs with AWVALID=1 the next cycle (latency 1); likewise W beats.
REQ-020 Slice valid clears on downstream handshake unless reloaded same cycle; simultaneous drain+load SHALL give back-to-back valid with new payload (full throughput, one word/cycle).
REQ-021 Slice payload SHALL hold stable while valid && !ready (AXI stability).
REQ-022 AW and W slices SHALL be independent: W beats flow while a prior AW is still stalled, and vice versa.
REQ-023 Beat counter (9 bits) SHALL load 0 on command accept and latch AWLEN into an 8-bit expected-length register; increment on each accepted W beat.
REQ-024 LEN_ERR SHALL set when a beat with WLAST=1 is accepted at count != expected, or a beat with WLAST=0 is accepted at count == expected.
REQ-025 WLAST SHALL be forwarded exactly as received; length errors SHALL not alter payload or FSM sequencing.
REQ-026 ERR_CLR=1 clears LEN_ERR; a simultaneous set event wins (LEN_ERR=1).
REQ-027 Counter saturates at 511; no wrap.

Reset
REQ-028 Asynchronous assertion SHALL immediately force: state CMD, AWVALID=0, WVALID=0, LEN_ERR=0, counter 0, expected-length 0; payload registers 0.
REQ-029 READY SHALL be 1 while in reset (slices empty); words presented during reset are not captured.
REQ-030 Reset mid-burst discards slice contents; first accepted word after release is a command.

Verification
REQ-031 Single burst: cmd AWID=0x12,AWADDR=0x1_0000_0040,AWLEN=3 then 4 beats (last WLAST=1), all ready=1 -> AWVALID 1 cycle after cmd accept, 4 W beats back-to-back, LEN_ERR=0, FSM back in CMD.
REQ-032 Back-pressure: AWREADY=0 for 5 cycles after cmd -> AWVALID held, payload stable, W beats still forwarded; READY=0 on next cmd until AWREADY=1.
REQ-033 WREADY toggling 1/0 per cycle over AWLEN=7 burst -> 8 beats out in order, no loss/duplication, payload stable when stalled.
REQ-034 Early WLAST on beat 2 of AWLEN=3 -> LEN_ERR=1 next cycle, FSM returns CMD; next cmd decoded correctly; ERR_CLR pulse -> LEN_ERR=0.
REQ-035 Missing WLAST: AWLEN=0 beat with WLAST=0 -> LEN_ERR=1, FSM stays DATA until WLAST=1 beat.
REQ-036 RESETn low mid-burst with both slices valid -> AWVALID=WVALID=0 immediately; after release a command word is decoded on AW outputs.

Source files
------------

// File: rtl/w_forward_splitter_if.sv
// w_forward_splitter_if: merged AW/W input stream plus split AXI4 AW and W channels.
// master is the splitter's view (stream sink, AXI source); slave is the environment's view.
interface w_forward_splitter_if;
    logic [76:0] DATA;
    logic        VALID;
    logic        READY;
    logic [7:0]  AWID;
    logic [35:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWLOCK;
    logic [3:0]  AWCACHE;
    logic [2:0]  AWPROT;
    logic [3:0]  AWQOS;
    logic [3:0]  AWREGION;
    logic [3:0]  AWUSER;
    logic        AWVALID;
    logic        AWREADY;
    logic [63:0] WDATA;
    logic [7:0]  WSTRB;
    logic [3:0]  WUSER;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic        LEN_ERR;
    logic        ERR_CLR;

    modport master (
        input  DATA, VALID, AWREADY, WREADY, ERR_CLR,
        output READY, AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT,
               AWQOS, AWREGION, AWUSER, AWVALID, WDATA, WSTRB, WUSER, WLAST, WVALID, LEN_ERR
    );

    modport slave (
        output DATA, VALID, AWREADY, WREADY, ERR_CLR,
        input  READY, AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT,
               AWQOS, AWREGION, AWUSER, AWVALID, WDATA, WSTRB, WUSER, WLAST, WVALID, LEN_ERR
    );
endinterface

// File: rtl/w_forward_splitter.sv
// w_forward_splitter: splits a merged command/data word stream into AXI4 AW and W channels
// through independent one-entry register slices, with optional sticky burst-length checking.
module w_forward_splitter #(
    parameter bit CHECK_LEN = 1'b1
) (
    input logic                   CLK,
    input logic                   RESETn,
    w_forward_splitter_if.master  bus
);
    typedef enum logic {S_CMD, S_DATA} state_t;

    state_t      state_q, state_d;
    logic [76:0] aw_q, aw_d, w_q, w_d;
    logic        aw_vld_q, aw_vld_d, w_vld_q, w_vld_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [7:0]  exp_q, exp_d;
    logic        err_q, err_d;
    logic        ready, cmd_acc, beat_acc, err_set;

    // READY only looks at the slice that the current word is destined for
    always_comb begin
        ready    = (state_q == S_CMD) ? (!aw_vld_q || bus.AWREADY) : (!w_vld_q || bus.WREADY);
        cmd_acc  = bus.VALID && ready && (state_q == S_CMD);
        beat_acc = bus.VALID && ready && (state_q == S_DATA);
        state_d  = cmd_acc ? S_DATA : (beat_acc && bus.DATA[0]) ? S_CMD : state_q;
        aw_d     = cmd_acc ? bus.DATA : aw_q;
        aw_vld_d = cmd_acc || (aw_vld_q && !bus.AWREADY);
        w_d      = beat_acc ? bus.DATA : w_q;
        w_vld_d  = beat_acc || (w_vld_q && !bus.WREADY);
        cnt_d    = cmd_acc ? 9'd0 : (beat_acc && cnt_q != 9'd511) ? cnt_q + 9'd1 : cnt_q;
        exp_d    = cmd_acc ? bus.DATA[32:25] : exp_q;
        err_set  = beat_acc && (bus.DATA[0] ? (cnt_q != {1'b0, exp_q}) : (cnt_q == {1'b0, exp_q}));
        err_d    = CHECK_LEN && (err_set || (err_q && !bus.ERR_CLR));
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q  <= S_CMD;
            aw_q     <= '0;
            w_q      <= '0;
            aw_vld_q <= 1'b0;
            w_vld_q  <= 1'b0;
            cnt_q    <= '0;
            exp_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            aw_q     <= aw_d;
            w_q      <= w_d;
            aw_vld_q <= aw_vld_d;
            w_vld_q  <= w_vld_d;
            cnt_q    <= cnt_d;
            exp_q    <= exp_d;
            err_q    <= err_d;
        end
    end

    assign bus.READY   = ready;
    assign bus.AWVALID = aw_vld_q;
    assign bus.WVALID  = w_vld_q;
    assign bus.LEN_ERR = err_q;
    assign {bus.AWID, bus.AWADDR, bus.AWLEN, bus.AWSIZE, bus.AWBURST, bus.AWLOCK,
            bus.AWCACHE, bus.AWPROT, bus.AWQOS, bus.AWREGION, bus.AWUSER} = aw_q;
    assign {bus.WDATA, bus.WSTRB, bus.WUSER, bus.WLAST} = w_q;
endmodule

// File: tb/tb_w_forward_splitter.sv
// tb_w_forward_splitter: directed checks of stream splitting, back-pressure, length errors and reset.
module tb_w_forward_splitter;
    logic CLK;
    logic RESETn;
    int   total;
    int   bad;
    int   sent;
    int   got;
    logic stalled;
    logic [63:0] held;

    w_forward_splitter_if bus();

    w_forward_splitter #(.CHECK_LEN(1'b1)) dut (
        .CLK(CLK),
        .RESETn(RESETn),
        .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [76:0] mk_cmd(input logic [7:0] id, input logic [35:0] addr, input logic [7:0] len);
        return {id, addr, len, 3'd3, 2'd1, 1'b0, 4'h3, 3'd0, 4'd0, 4'd0, 4'h5};
    endfunction

    function automatic logic [76:0] mk_beat(input logic [63:0] d, input logic last);
        return {d, 8'hFF, 4'hA, last};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad = 0;
        RESETn = 1'b0;
        bus.VALID = 1'b1;
        bus.DATA = mk_cmd(8'hEE, 36'h5, 8'd9);
        bus.AWREADY = 1'b1;
        bus.WREADY = 1'b1;
        bus.ERR_CLR = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_awvalid", 80'(bus.AWVALID), 80'(0));
        chk("rst_wvalid", 80'(bus.WVALID), 80'(0));
        chk("rst_len_err", 80'(bus.LEN_ERR), 80'(0));
        chk("rst_ready", 80'(bus.READY), 80'(1));
        chk("rst_awid", 80'(bus.AWID), 80'(0));
        RESETn = 1'b1;
        bus.VALID = 1'b0;
        @(negedge CLK);
        chk("rst_no_capture", 80'(bus.AWVALID), 80'(0));

        // single burst, all ready
        bus.DATA = mk_cmd(8'h12, 36'h1_0000_0040, 8'd3);
        bus.VALID = 1'b1;
        #1 chk("b1_ready", 80'(bus.READY), 80'(1));
        @(negedge CLK);
        chk("b1_awvalid", 80'(bus.AWVALID), 80'(1));
        chk("b1_awid", 80'(bus.AWID), 80'(8'h12));
        chk("b1_awaddr", 80'(bus.AWADDR), 80'(36'h1_0000_0040));
        chk("b1_awlen", 80'(bus.AWLEN), 80'(3));
        chk("b1_awuser", 80'(bus.AWUSER), 80'(5));
        chk("b1_awsize", 80'(bus.AWSIZE), 80'(3));
        chk("b1_wvalid0", 80'(bus.WVALID), 80'(0));
        for (int i = 0; i < 4; i++) begin
            bus.DATA = mk_beat(64'hA0 + 64'(i), i == 3);
            @(negedge CLK);
            chk("b1_wvalid", 80'(bus.WVALID), 80'(1));
            chk("b1_wdata", 80'(bus.WDATA), 80'(64'hA0 + 64'(i)));
            chk("b1_wlast", 80'(bus.WLAST), 80'(i == 3));
            if (i == 0) chk("b1_aw_drained", 80'(bus.AWVALID), 80'(0));
        end
        chk("b1_wstrb", 80'(bus.WSTRB), 80'(8'hFF));
        bus.VALID = 1'b0;
        @(negedge CLK);
        chk("b1_w_drained", 80'(bus.WVALID), 80'(0));
        chk("b1_len_err", 80'(bus.LEN_ERR), 80'(0));

        // AW back-pressure while W beats keep flowing
        bus.AWREADY = 1'b0;
        bus.DATA = mk_cmd(8'h34, 36'h2000, 8'd1);
        bus.VALID = 1'b1;
        @(negedge CLK);
        chk("bp_awvalid", 80'(bus.AWVALID), 80'(1));
        chk("bp_awid", 80'(bus.AWID), 80'(8'h34));
        bus.DATA = mk_beat(64'hB0, 1'b0);
        @(negedge CLK);
        chk("bp_aw_held", 80'(bus.AWVALID), 80'(1));
        chk("bp_w0", 80'(bus.WDATA), 80'(64'hB0));
        chk("bp_w0_valid", 80'(bus.WVALID), 80'(1));
        bus.DATA = mk_beat(64'hB1, 1'b1);
        @(negedge CLK);
        chk("bp_w1", 80'(bus.WDATA), 80'(64'hB1));
        chk("bp_w1_last", 80'(bus.WLAST), 80'(1));
        bus.DATA = mk_cmd(8'h56, 36'h3000, 8'd0);
        #1 chk("bp_ready_low", 80'(bus.READY), 80'(0));
        repeat (2) begin
            @(negedge CLK);
            chk("bp_ready_held", 80'(bus.READY), 80'(0));
            chk("bp_awid_stable", 80'(bus.AWID), 80'(8'h34));
            chk("bp_awaddr_stable", 80'(bus.AWADDR), 80'(36'h2000));
        end
        chk("bp_w_drained", 80'(bus.WVALID), 80'(0));
        bus.AWREADY = 1'b1;
        #1 chk("bp_ready_high", 80'(bus.READY), 80'(1));
        @(negedge CLK);
        chk("bp_b2b_valid", 80'(bus.AWVALID), 80'(1));
        chk("bp_b2b_awid", 80'(bus.AWID), 80'(8'h56));
        chk("bp_b2b_awaddr", 80'(bus.AWADDR), 80'(36'h3000));
        bus.DATA = mk_beat(64'hC0, 1'b1);
        @(negedge CLK);
        chk("bp_aw_gone", 80'(bus.AWVALID), 80'(0));
        chk("bp_c0", 80'(bus.WDATA), 80'(64'hC0));
        chk("bp_len_err", 80'(bus.LEN_ERR), 80'(0));

        // WREADY toggling over an 8-beat burst
        bus.DATA = mk_cmd(8'h78, 36'h4000, 8'd7);
        @(negedge CLK);
        chk("tg_awlen", 80'(bus.AWLEN), 80'(7));
        sent = 0;
        got = 0;
        stalled = 1'b0;
        held = '0;
        for (int c = 0; c < 60 && got < 8; c++) begin
            bus.WREADY = (c % 2) == 0;
            bus.VALID = sent < 8;
            bus.DATA = mk_beat(64'hC00 + 64'(sent), sent == 7);
            #1;
            if (stalled) chk("tg_stable", 80'(bus.WDATA), 80'(held));
            if (bus.WVALID && bus.WREADY) begin
                chk("tg_order", 80'(bus.WDATA), 80'(64'hC00 + 64'(got)));
                got++;
            end
            stalled = bus.WVALID && !bus.WREADY;
            held = bus.WDATA;
            if (bus.VALID && bus.READY) sent++;
            @(negedge CLK);
        end
        chk("tg_count", 80'(got), 80'(8));
        chk("tg_len_err", 80'(bus.LEN_ERR), 80'(0));
        bus.VALID = 1'b0;
        bus.WREADY = 1'b1;

        // early WLAST, then clear
        bus.DATA = mk_cmd(8'h9A, 36'h5000, 8'd3);
        bus.VALID = 1'b1;
        @(negedge CLK);
        bus.DATA = mk_beat(64'hD0, 1'b0);
        @(negedge CLK);
        bus.DATA = mk_beat(64'hD1, 1'b1);
        @(negedge CLK);
        chk("el_len_err", 80'(bus.LEN_ERR), 80'(1));
        chk("el_wlast_fwd", 80'(bus.WLAST), 80'(1));
        bus.DATA = mk_cmd(8'hBC, 36'h6000, 8'd2);
        @(negedge CLK);
        chk("el_next_awvalid", 80'(bus.AWVALID), 80'(1));
        chk("el_next_awid", 80'(bus.AWID), 80'(8'hBC));
        chk("el_next_awlen", 80'(bus.AWLEN), 80'(2));
        chk("el_sticky", 80'(bus.LEN_ERR), 80'(1));
        bus.VALID = 1'b0;
        bus.ERR_CLR = 1'b1;
        @(negedge CLK);
        chk("el_cleared", 80'(bus.LEN_ERR), 80'(0));
        bus.ERR_CLR = 1'b0;
        bus.VALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.DATA = mk_beat(64'hE0 + 64'(i), i == 2);
            @(negedge CLK);
        end
        chk("el_good_burst", 80'(bus.LEN_ERR), 80'(0));
        chk("el_good_last", 80'(bus.WDATA), 80'(64'hE2));

        // missing WLAST keeps FSM in DATA; set beats a simultaneous clear
        bus.DATA = mk_cmd(8'hDE, 36'h7000, 8'd0);
        @(negedge CLK);
        bus.DATA = mk_beat(64'hF0, 1'b0);
        @(negedge CLK);
        chk("ml_len_err", 80'(bus.LEN_ERR), 80'(1));
        chk("ml_wdata", 80'(bus.WDATA), 80'(64'hF0));
        chk("ml_wlast", 80'(bus.WLAST), 80'(0));
        bus.DATA = mk_beat(64'hF1, 1'b1);
        bus.ERR_CLR = 1'b1;
        @(negedge CLK);
        chk("ml_stay_data_w", 80'(bus.WDATA), 80'(64'hF1));
        chk("ml_stay_data_aw", 80'(bus.AWVALID), 80'(0));
        chk("ml_set_wins", 80'(bus.LEN_ERR), 80'(1));
        bus.VALID = 1'b0;
        @(negedge CLK);
        chk("ml_cleared", 80'(bus.LEN_ERR), 80'(0));
        bus.ERR_CLR = 1'b0;

        // reset mid-burst with both slices valid
        bus.AWREADY = 1'b0;
        bus.WREADY = 1'b0;
        bus.DATA = mk_cmd(8'h11, 36'h8000, 8'd1);
        bus.VALID = 1'b1;
        @(negedge CLK);
        bus.DATA = mk_beat(64'h90, 1'b0);
        @(negedge CLK);
        chk("rm_aw_full", 80'(bus.AWVALID), 80'(1));
        chk("rm_w_full", 80'(bus.WVALID), 80'(1));
        #2 RESETn = 1'b0;
        #1;
        chk("rm_aw_async", 80'(bus.AWVALID), 80'(0));
        chk("rm_w_async", 80'(bus.WVALID), 80'(0));
        chk("rm_ready", 80'(bus.READY), 80'(1));
        chk("rm_wdata_zero", 80'(bus.WDATA), 80'(0));
        bus.DATA = mk_beat(64'h91, 1'b1);
        repeat (2) @(negedge CLK);
        chk("rm_no_capture", 80'(bus.WVALID), 80'(0));
        RESETn = 1'b1;
        bus.AWREADY = 1'b1;
        bus.WREADY = 1'b1;
        bus.DATA = mk_cmd(8'h22, 36'h9000, 8'd0);
        @(negedge CLK);
        chk("rm_cmd_valid", 80'(bus.AWVALID), 80'(1));
        chk("rm_cmd_awid", 80'(bus.AWID), 80'(8'h22));
        chk("rm_cmd_addr", 80'(bus.AWADDR), 80'(36'h9000));
        bus.DATA = mk_beat(64'h92, 1'b1);
        @(negedge CLK);
        chk("rm_beat", 80'(bus.WDATA), 80'(64'h92));
        chk("rm_len_err", 80'(bus.LEN_ERR), 80'(0));
        bus.VALID = 1'b0;
        @(negedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
